// File: rtl/croc_pkg.sv
// Shared SoC types: user-domain OBI subordinate request/response and the GPIO IRQ register offsets.
package croc_pkg;

   localparam int unsigned SbrObiAidWidth = 2;

   typedef struct packed {
      logic [31:0]               addr;
      logic                      we;
      logic [3:0]                be;
      logic [31:0]               wdata;
      logic [SbrObiAidWidth-1:0] aid;
   } sbr_obi_a_chan_t;

   typedef struct packed {
      logic            req;
      sbr_obi_a_chan_t a;
   } sbr_obi_req_t;

   typedef struct packed {
      logic [31:0]               rdata;
      logic [SbrObiAidWidth-1:0] rid;
      logic                      err;
   } sbr_obi_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      sbr_obi_r_chan_t r;
   } sbr_obi_rsp_t;

   localparam logic [3:0] GpioIrqRiseEnOffset = 4'h0;
   localparam logic [3:0] GpioIrqFallEnOffset = 4'h4;
   localparam logic [3:0] GpioIrqStatusOffset = 4'h8;
   localparam logic [3:0] GpioIrqLevelOffset  = 4'hC;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/user_gpio_irq_debounce.sv
// Single-pin debounce filter: output follows the raw input only after it has
// differed from the filtered value for DebounceCycles consecutive cycles.
module user_gpio_irq_debounce #(
   parameter int unsigned DebounceCycles = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic primed_i,
   input  logic raw_i,
   output logic filt_o
);

   localparam int unsigned    CntW    = $clog2(DebounceCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic            r_filt;
   logic [CntW-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_filt <= 1'b0;
         r_cnt  <= '0;
      end else if (!primed_i) begin
         r_filt <= raw_i;
         r_cnt  <= '0;
      end else if (raw_i != r_filt) begin
         if (r_cnt == CntLast) begin
            r_filt <= raw_i;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   assign filt_o = r_filt;

endmodule

// File: rtl/user_gpio_irq.sv
// GPIO edge interrupt controller on the user OBI port: RISE_EN/FALL_EN/STATUS(W1C)/LEVEL.
// Define USER_GPIO_IRQ_DEBOUNCE_EN to insert a per-pin debounce filter ahead of edge detection.
module user_gpio_irq
   import croc_pkg::*;
#(
   parameter int unsigned GpioCount      = 16,
   parameter int unsigned DebounceCycles = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  sbr_obi_req_t         obi_req_i,
   output sbr_obi_rsp_t         obi_rsp_o,
   input  logic [GpioCount-1:0] gpio_in_sync_i,
   output logic                 irq_o
);

   if (GpioCount < 1 || GpioCount > 32 || DebounceCycles < 1) begin : g_param_err
      $error("user_gpio_irq: GpioCount must be 1..32 and DebounceCycles >= 1");
   end

   logic [GpioCount-1:0] r_rise_en, r_fall_en, r_status, r_prev;
   logic                 r_primed, r_irq, r_rvalid;
   logic [31:0]          r_rdata;
   logic [SbrObiAidWidth-1:0] r_rid;

   logic [GpioCount-1:0] w_lvl, w_set, w_clr, w_wmask, w_wdata, w_rd_reg;
   logic [31:0]          w_bemask, w_rdata;
   logic                 w_wr, w_sel_rise, w_sel_fall, w_sel_status, w_unused;

`ifdef USER_GPIO_IRQ_DEBOUNCE_EN
   for (genvar gi = 0; gi < GpioCount; gi++) begin : g_deb
      user_gpio_irq_debounce #(
         .DebounceCycles(DebounceCycles)
      ) i_deb (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .primed_i(r_primed),
         .raw_i   (gpio_in_sync_i[gi]),
         .filt_o  (w_lvl[gi])
      );
   end
`else
   assign w_lvl = gpio_in_sync_i;
`endif

   assign w_bemask     = be_to_mask(obi_req_i.a.be);
   assign w_wmask      = w_bemask[GpioCount-1:0];
   assign w_wdata      = obi_req_i.a.wdata[GpioCount-1:0];
   assign w_wr         = obi_req_i.req & obi_req_i.a.we;
   assign w_sel_rise   = obi_req_i.a.addr[3:2] == GpioIrqRiseEnOffset[3:2];
   assign w_sel_fall   = obi_req_i.a.addr[3:2] == GpioIrqFallEnOffset[3:2];
   assign w_sel_status = obi_req_i.a.addr[3:2] == GpioIrqStatusOffset[3:2];

   // No detection until prev holds a real sample, so pins already high at reset stay quiet.
   assign w_set = r_primed ? (((w_lvl & ~r_prev) & r_rise_en) | ((~w_lvl & r_prev) & r_fall_en))
                           : '0;
   assign w_clr = (w_wr && w_sel_status) ? (w_wdata & w_wmask) : '0;

   always_comb begin
      w_rd_reg = '0;
      unique case (obi_req_i.a.addr[3:2])
         GpioIrqRiseEnOffset[3:2]: w_rd_reg = r_rise_en;
         GpioIrqFallEnOffset[3:2]: w_rd_reg = r_fall_en;
         GpioIrqStatusOffset[3:2]: w_rd_reg = r_status;
         default:                  w_rd_reg = w_lvl;
      endcase
      w_rdata                = '0;
      w_rdata[GpioCount-1:0] = w_rd_reg;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_status  <= '0;
         r_prev    <= '0;
         r_primed  <= 1'b0;
         r_irq     <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rid     <= '0;
         r_rdata   <= '0;
      end else begin
         r_primed <= 1'b1;
         // In debounce builds the filter output is still 0 during the unprimed cycle.
         r_prev   <= r_primed ? w_lvl : gpio_in_sync_i;
         if (w_wr && w_sel_rise) r_rise_en <= (r_rise_en & ~w_wmask) | (w_wdata & w_wmask);
         if (w_wr && w_sel_fall) r_fall_en <= (r_fall_en & ~w_wmask) | (w_wdata & w_wmask);
         r_status <= (r_status & ~w_clr) | w_set;
         r_irq    <= |r_status;
         r_rvalid <= obi_req_i.req;
         r_rid    <= obi_req_i.a.aid;
         r_rdata  <= (obi_req_i.req && !obi_req_i.a.we) ? w_rdata : '0;
      end
   end

   assign obi_rsp_o.gnt     = 1'b1;
   assign obi_rsp_o.rvalid  = r_rvalid;
   assign obi_rsp_o.r.rdata = r_rdata;
   assign obi_rsp_o.r.rid   = r_rid;
   assign obi_rsp_o.r.err   = 1'b0;
   assign irq_o             = r_irq;

   assign w_unused = ^{obi_req_i.a.addr, obi_req_i.a.wdata, w_bemask};

endmodule

// File: doc/user_gpio_irq.md
# user_gpio_irq

OBI subordinate in the user domain that turns the synchronised GPIO inputs into a level interrupt for the core. It sits between the SoC's synchronised GPIO bus and one bit of the user-domain interrupt vector. It provides per-pin rising/falling edge enables, a sticky write-1-to-clear status register, and a combined interrupt line. Software configures and services it through the user subordinate OBI port.

## Interface
Parameters:
- GpioCount, 16, number of GPIO pins monitored (1..32)
- DebounceCycles, 4, stable cycles required by the debounce filter (>=1; used only with the debounce macro)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; synchronous and active-low, sampled on the rising clk_i edge
- obi_req_i  in  sbr_obi_req_t  OBI request from the user-domain subordinate demux
- obi_rsp_o  out  sbr_obi_rsp_t  OBI response
- gpio_in_sync_i  in  GpioCount  GPIO inputs, already synchronised to clk_i
- irq_o  out  1  interrupt, active-high level; drives one bit of interrupts_o

## Operation
- Register map (word offset addr[3:2]); bits above GpioCount read 0 and ignore writes:
  - 0x0 RISE_EN: rw.
  - 0x4 FALL_EN: rw.
  - 0x8 STATUS: read; write-1-to-clear.
  - 0xC LEVEL: ro; current filtered pin values.
  - Writes to LEVEL are ignored with no error.
- Address decode uses addr[3:2] only. The upstream demux guarantees the region; there are no unmapped offsets.
- Byte enables apply per byte to RW and W1C writes.
- Edge detection:
  - Keep a per-pin previous value and a `primed` flag.
  - Rising edge on pin i = lvl[i] & ~prev[i]; falling edge = ~lvl[i] & prev[i].
  - STATUS[i] is set when (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
- After reset, `primed`=0. The first cycle only loads prev ← lvl and sets primed, with no detection, so a pin high at reset produces no edge.
- A set and a W1C on the same STATUS bit in the same cycle: the set wins.
- Disabling an enable does not clear existing STATUS bits.
- irq_o is registered |STATUS.
- Reset values:
  - RISE_EN, FALL_EN, STATUS, prev, primed, irq_o = 0.
  - obi_rsp_o.rvalid = 0, obi_rsp_o.r.err = 0, obi_rsp_o.r.rdata = 0.

## Timing
- obi_rsp_o.gnt is tied to 1; every request is accepted in its req cycle.
- Response timing for a request accepted in cycle N:
  - rvalid=1 in cycle N+1 with rid = the captured aid and err=0.
  - rdata = the register value sampled in cycle N (pre-write for read-modify, post-nothing).
  - A write produces rvalid with rdata=0.
- Back-to-back requests are allowed every cycle. There is no backpressure; rready is not part of the protocol.
- Write effect: visible to a read issued in cycle N+1.
- Edge latency without debounce:
  - gpio_in_sync_i changes in cycle N.
  - STATUS is set in cycle N+1.
  - irq_o is high in cycle N+2.
- Clearing: W1C in cycle N clears STATUS in cycle N+1; irq_o falls in cycle N+2 if no other bit is set.
- Reset mid-transaction: a pending rvalid is dropped (rvalid=0 the cycle after reset is sampled).

## Configuration
- USER_GPIO_IRQ_DEBOUNCE_EN defined:
  - Each pin passes through a filter before edge detection and LEVEL.
  - The filtered value changes only after the raw input has differed from it for DebounceCycles consecutive cycles.
  - Counter width is $clog2(DebounceCycles+1). The counter resets to 0 on any return to the filtered value.
  - Filter state resets to 0 and loads raw values during the unprimed cycle.
  - Edge latency becomes DebounceCycles+1 cycles to STATUS.
- USER_GPIO_IRQ_DEBOUNCE_EN undefined: lvl = gpio_in_sync_i directly; DebounceCycles is ignored.

## Structure
- Shared package croc_pkg holds:
  - sbr_obi_req_t / sbr_obi_rsp_t.
  - Register offset localparams: GpioIrqRiseEnOffset, GpioIrqFallEnOffset, GpioIrqStatusOffset, GpioIrqLevelOffset.
- One sub-module, user_gpio_irq_debounce: a single-pin filter instantiated GpioCount times in a generate loop, present only under the macro.

## Test plan
- Reset with gpio_in_sync_i=16'hFFFF and RISE_EN written to 16'hFFFF immediately after reset -> STATUS stays 0, irq_o stays 0.
- RISE_EN=16'h0001; drive pin0 0→1 in cycle N -> STATUS=16'h0001 in N+1, irq_o=1 in N+2. Write STATUS=16'h0001 -> irq_o=0 two cycles later.
- FALL_EN=16'h8000; pin15 1→0 -> STATUS=16'h8000. A rising edge on pin15 causes no change.
- Issue a W1C to bit 3 in the same cycle that pin3 has an enabled rising edge -> STATUS[3] remains 1.
- Back-to-back requests: write RISE_EN=16'hA5A5 with be=4'b0001, then read RISE_EN the next cycle -> read returns 16'h00A5, rvalid in consecutive cycles, rid matches each aid.
- With USER_GPIO_IRQ_DEBOUNCE_EN and DebounceCycles=4:
  - A 3-cycle glitch on pin2 -> no STATUS change.
  - A 4-cycle stable high on pin2 -> STATUS[2]=1 five cycles after the input change.
